// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_ctrl load/store controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        DONE
    } state_e;

    localparam logic [31:0] DATA_BASE_DFLT = 32'h0000_0400;

    // Illegal size code or an address not aligned to the access size.
    function automatic logic is_bad_access(input size_e sz, input logic [1:0] off);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side and memory-side bundles of the mem_ctrl controller.
interface mem_ctrl_cpu_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, size, sign, addr, wdata,
                    input  ready, done, rdata, err);
    modport slave  (input  req, we, size, sign, addr, wdata,
                    output ready, done, rdata, err);
endinterface

interface mem_ctrl_mem_if;
    logic [31:0] mem_addr;
    logic        mem_W;
    logic        mem_R;
    logic [31:0] mem_W_data;
    logic [31:0] mem_R_data;

    modport master (output mem_addr, mem_W, mem_R, mem_W_data,
                    input  mem_R_data);
    modport slave  (input  mem_addr, mem_W, mem_R, mem_W_data,
                    output mem_R_data);
endinterface

// File: rtl/mem_ctrl_lane.sv
// Byte-lane extract/extend for loads and lane merge for sub-word stores.
module mem_ctrl_lane
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  size_e       size_i,
    input  logic        sign_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  sh;
    logic [15:0] lane;

    assign sh   = {off_i, 3'b000};
    assign lane = 16'(word_i >> sh);

    // Halves are aligned, so the same byte shift serves both widths.
    always_comb begin
        load_o  = word_i;
        merge_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o  = {{24{sign_i & lane[7]}}, lane[7:0]};
                merge_o = (word_i & ~(32'h0000_00FF << sh)) | ({24'h0, wdata_i[7:0]} << sh);
            end
            SZ_HALF: begin
                load_o  = {{16{sign_i & lane[15]}}, lane};
                merge_o = (word_i & ~(32'h0000_FFFF << sh)) | ({16'h0, wdata_i[15:0]} << sh);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port load/store controller: aligned word, half and byte accesses
// against a word-wide memory, read-modify-write for sub-word stores.
// Optional build macro MEM_CTRL_WPROT_EN faults stores below DATA_BASE.
//
// state  | meaning
// IDLE   | ready, waiting for req
// RD     | load read cycle, result captured at the edge
// RMW_RD | sub-word store read, merged word captured at the edge
// WR     | write strobe to memory
// DONE   | one-cycle completion pulse (err valid here)
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] DATA_BASE = DATA_BASE_DFLT
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_ctrl_cpu_if.slave  cpu,
    mem_ctrl_mem_if.master mem
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    size_e       size_q;
    logic        sign_q, err_q;
    logic        accept, fault, prot_hit;
    logic [31:0] lane_load, lane_merge;

    assign accept = (state_q == IDLE) && cpu.req;

`ifdef MEM_CTRL_WPROT_EN
    assign prot_hit = cpu.we && (cpu.addr < DATA_BASE);
`else
    // DATA_BASE only matters when write protection is built in.
    logic unused_base;
    assign unused_base = ^DATA_BASE;
    assign prot_hit    = 1'b0;
`endif

    assign fault = is_bad_access(size_e'(cpu.size), cpu.addr[1:0]) || prot_hit;

    mem_ctrl_lane u_lane (
        .word_i  (mem.mem_R_data),
        .off_i   (addr_q[1:0]),
        .size_i  (size_q),
        .sign_i  (sign_q),
        .wdata_i (wdata_q),
        .load_o  (lane_load),
        .merge_o (lane_merge)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; the load/store direction is carried by the state path.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu.req) begin
                    if (fault)                          state_d = DONE;
                    else if (!cpu.we)                   state_d = RD;
                    else if (size_e'(cpu.size) == SZ_WORD) state_d = WR;
                    else                                state_d = RMW_RD;
                end
            end
            RD:      state_d = DONE;
            RMW_RD:  state_d = WR;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, load result and merged store word; memory data is only
    // captured in the states that assert mem_R.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= cpu.addr;
                size_q  <= size_e'(cpu.size);
                sign_q  <= cpu.sign;
                wdata_q <= cpu.wdata;
                err_q   <= fault;
            end
            if (state_q == RD)     rdata_q <= lane_load;
            if (state_q == RMW_RD) wdata_q <= lane_merge;
        end
    end

    // Memory strobes and CPU status decoded from the current state.
    always_comb begin
        mem.mem_addr   = '0;
        mem.mem_R      = 1'b0;
        mem.mem_W      = 1'b0;
        mem.mem_W_data = '0;
        if (state_q != IDLE) mem.mem_addr = {addr_q[31:2], 2'b00};
        case (state_q)
            RD, RMW_RD: mem.mem_R = 1'b1;
            WR: begin
                mem.mem_W      = 1'b1;
                mem.mem_W_data = wdata_q;
            end
            default: ;
        endcase
        cpu.ready = (state_q == IDLE);
        cpu.done  = (state_q == DONE);
        cpu.err   = (state_q == DONE) && err_q;
        cpu.rdata = rdata_q;
    end

endmodule
